// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: owns the architectural HI/LO registers and runs iterative
// 32-bit shift-add multiply and restoring divide (33 cycles of Busy per op).
// MTHI/MTLO write in a single cycle.
// Optional macro HILO_MADD_EN enables MADD/MSUB: a signed multiply whose
// product is added to / subtracted from HI:LO in the FIX cycle.
//
// state | meaning
// IDLE  | waiting for Start; MTHI/MTLO complete here
// RUN   | one multiply/divide iteration per cycle, counter 0..31
// FIX   | sign correction, HI/LO write, Done pulse; accepts a new iterative op
module hilo_muldiv_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // Multiply: product/multiplier shift register. Divide: {remainder, quotient}.
  logic [63:0] wk_q, wk_d;
  // Multiply: multiplicand magnitude. Divide: divisor magnitude.
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] araw_q, araw_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, done_q, done_d;
`ifdef HILO_MADD_EN
  // 2'b01 accumulate (MADD), 2'b10 subtract (MSUB), 2'b00 plain result
  logic [1:0]  acc_q, acc_d;
`endif

  logic        iter_req, op_signed, op_div;
  logic [31:0] mag_a, mag_b;

  // Decode the incoming request and form operand magnitudes
  always_comb begin
    op_div    = (Op == OP_DIV) || (Op == OP_DIVU);
    op_signed = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
    iter_req  = Start && (Op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
`ifdef HILO_MADD_EN
    if (Start && (Op inside {OP_MADD, OP_MSUB})) iter_req = 1'b1;
`endif
    mag_a = (op_signed && A[31]) ? -A : A;
    mag_b = (op_signed && B[31]) ? -B : B;
  end

  logic [32:0] mul_sum, div_trial;
  logic        div_ge;
  logic [63:0] wk_step;

  // One multiply or restoring-divide iteration on the working registers
  always_comb begin
    mul_sum   = {1'b0, wk_q[63:32]} + (wk_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_trial = {wk_q[63:32], wk_q[31]};
    div_ge    = div_trial >= {1'b0, opnd_q};
    if (is_div_q) begin
      // After a successful subtract the remainder is below the divisor, so 32 bits hold it
      if (div_ge) wk_step = {div_trial[31:0] - opnd_q, wk_q[30:0], 1'b1};
      else        wk_step = {div_trial[31:0], wk_q[30:0], 1'b0};
    end else begin
      wk_step = {mul_sum, wk_q[31:1]};
    end
  end

  logic [63:0] prod, fix_hilo;
  logic [31:0] quo, rem;

  // Sign correction and final HI:LO value written in FIX
  always_comb begin
    prod = neg_res_q ? -wk_q : wk_q;
    quo  = neg_res_q ? -wk_q[31:0] : wk_q[31:0];
    rem  = neg_rem_q ? -wk_q[63:32] : wk_q[63:32];
    if (is_div_q) begin
      if (opnd_q == 32'd0) fix_hilo = {araw_q, 32'hFFFF_FFFF};
      else                 fix_hilo = {rem, quo};
    end else begin
      fix_hilo = prod;
`ifdef HILO_MADD_EN
      if (acc_q == 2'b01)      fix_hilo = {hi_q, lo_q} + prod;
      else if (acc_q == 2'b10) fix_hilo = {hi_q, lo_q} - prod;
`endif
    end
  end

  logic launch;

  // Next-state logic: sequencing, operand latch and HI/LO updates
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wk_d      = wk_q;
    opnd_d    = opnd_q;
    araw_d    = araw_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    launch    = 1'b0;
`ifdef HILO_MADD_EN
    acc_d     = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (iter_req) begin
          launch = 1'b1;
        end else if (Start && Op == OP_MTHI) begin
          hi_d   = A;
          done_d = 1'b1;
        end else if (Start && Op == OP_MTLO) begin
          lo_d   = A;
          done_d = 1'b1;
        end
      end
      S_RUN: begin
        wk_d  = wk_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        {hi_d, lo_d} = fix_hilo;
        done_d       = 1'b1;
        state_d      = S_IDLE;
        // MTHI/MTLO here would collide with the result write, so only iterative ops start
        if (iter_req) launch = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (launch) begin
      state_d   = S_RUN;
      cnt_d     = 5'd0;
      is_div_d  = op_div;
      araw_d    = A;
      wk_d      = {32'd0, op_div ? mag_a : mag_b};
      opnd_d    = op_div ? mag_b : mag_a;
      neg_res_d = op_signed && (A[31] ^ B[31]);
      neg_rem_d = op_signed && op_div && A[31];
`ifdef HILO_MADD_EN
      acc_d     = (Op == OP_MADD) ? 2'b01 : (Op == OP_MSUB) ? 2'b10 : 2'b00;
`endif
    end
  end

  // State and datapath registers; reset aborts any op in flight
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      wk_q      <= 64'd0;
      opnd_q    <= 32'd0;
      araw_q    <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef HILO_MADD_EN
      acc_q     <= 2'b00;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wk_q      <= wk_d;
      opnd_q    <= opnd_d;
      araw_q    <= araw_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= done_d;
`ifdef HILO_MADD_EN
      acc_q     <= acc_d;
`endif
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: directed cases plus randomized ops,
// checked against an arithmetic reference model of HI/LO and op timing.
module tb_hilo_muldiv_unit;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  hilo_muldiv_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  bit          exp_busy[int];
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          fe = 0;   // edge at which the in-flight op writes HI/LO

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: HI:LO result of an op from plain arithmetic
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hilo);
    longint sa, sb_, q, r;
    logic [63:0] qv, rv, res;
    sa = $signed(a);
    sb_ = $signed(b);
    res = hilo;
    case (op)
      3'b000: res = sa * sb_;
      3'b001: res = {32'd0, a} * {32'd0, b};
      3'b010: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb_; r = sa % sb_;
          qv = q; rv = r;
          res = {rv[31:0], qv[31:0]};
        end
      end
      3'b011: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      3'b110: res = hilo + sa * sb_;
      3'b111: res = hilo - sa * sb_;
      default: res = hilo;
    endcase
    return res;
  endfunction

  task automatic wait_until_edge(input int e);
    while (cyc + 1 < e) @(negedge Clk);
  endtask

  task automatic wait_free();
    while (cyc + 1 <= fe) @(negedge Clk);
  endtask

  // Drive one Start for the next edge; the model decides whether it is accepted
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int e;
    bit acc, iter;
    exp_t x;
    logic [63:0] r;
    e = cyc + 1;
    iter = (op[2] == 1'b0);
`ifdef HILO_MADD_EN
    if (op[2:1] == 2'b11) iter = 1'b1;
`endif
    if (op == 3'b100 || op == 3'b101) acc = (e > fe);
    else if (iter) acc = (e >= fe);
    else acc = 1'b0;
    Start = 1'b1; Op = op; A = a; B = b;
    if (acc) begin
      if (op == 3'b100)      r = {a, m_lo};
      else if (op == 3'b101) r = {m_hi, a};
      else                   r = model(op, a, b, {m_hi, m_lo});
      {m_hi, m_lo} = r;
      x.hi = r[63:32];
      x.lo = r[31:0];
      if (iter) begin
        x.cyc = e + 33;
        fe = e + 33;
        for (int c = e; c <= e + 32; c++) exp_busy[c] = 1'b1;
      end else begin
        x.cyc = e;
      end
      sb.push_back(x);
    end
    @(negedge Clk);
    Start = 1'b0; Op = 3'($urandom); A = $urandom; B = $urandom;
  endtask

  function automatic logic [31:0] pick_a();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'd0;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 200));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] pick_b();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'd1;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  exp_t mx;
  // Monitor: Busy every cycle, and HI/LO/timing whenever Done is presented
  always @(negedge Clk) begin
    if (mon_en && !Reset) begin
      chk("busy", {63'd0, Busy}, {63'd0, exp_busy.exists(cyc)});
      if (Done) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: Done=1 with nothing outstanding (cycle %0d)", cyc);
        end else begin
          mx = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(mx.cyc));
          chk("hi", {32'd0, Hi}, {32'd0, mx.hi});
          chk("lo", {32'd0, Lo}, {32'd0, mx.lo});
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        total++; bad++;
        $display("FAIL missing_done: no Done by cycle %0d expected at %0d", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  int k;
  logic [2:0] rop;

  initial begin
    Reset = 1'b1; Start = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0;
    repeat (3) @(negedge Clk);
    chk("rst_hi", {32'd0, Hi}, 64'd0);
    chk("rst_lo", {32'd0, Lo}, 64'd0);
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_done", {63'd0, Done}, 64'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // Reset at RUN iteration 10 of a MULT aborts with no HI/LO write
    Start = 1'b1; Op = 3'b000; A = 32'hFFFF_FFFE; B = 32'd3;
    @(negedge Clk);
    Start = 1'b0;
    repeat (10) @(negedge Clk);
    chk("midop_busy_before", {63'd0, Busy}, 64'd1);
    Reset = 1'b1;
    #1;
    chk("midop_busy", {63'd0, Busy}, 64'd0);
    chk("midop_hi", {32'd0, Hi}, 64'd0);
    chk("midop_lo", {32'd0, Lo}, 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    mon_en = 1'b1;
    repeat (40) @(negedge Clk);
    chk("abort_hi", {32'd0, Hi}, 64'd0);
    chk("abort_lo", {32'd0, Lo}, 64'd0);

    // Directed cases
    wait_free(); issue(3'b000, 32'hFFFF_FFFE, 32'd3);
    wait_free(); issue(3'b001, 32'hFFFF_FFFE, 32'd3);
    wait_free(); issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_free(); issue(3'b011, 32'd7, 32'd0);
    wait_free(); issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_free(); issue(3'b010, 32'hFFFF_FFEC, 32'd0);
    wait_free(); issue(3'b100, 32'h1234_5678, 32'd0);
    wait_free(); issue(3'b000, 32'd1000, 32'hFFFF_FFFD);
    k = fe - 33;
    wait_until_edge(k + 5); issue(3'b101, 32'hAAAA_0000, 32'd0);
    wait_free(); issue(3'b011, 32'd100, 32'd7);
    wait_until_edge(fe); issue(3'b001, 32'd4, 32'd5);
    wait_free(); issue(3'b100, 32'd0, 32'd0); issue(3'b101, 32'd5, 32'd0);
    issue(3'b110, 32'd2, 32'd3);
    wait_free(); issue(3'b100, 32'd0, 32'd0); issue(3'b101, 32'd5, 32'd0);
    issue(3'b111, 32'd4, 32'd4);
    wait_free(); repeat (3) @(negedge Clk);
    chk("acc_hold_hi", {32'd0, Hi}, {32'd0, m_hi});
    chk("acc_hold_lo", {32'd0, Lo}, {32'd0, m_lo});

    // Randomized traffic: back-to-back at FIX, gaps, and ignored mid-busy requests
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: wait_until_edge(fe);
        1: begin wait_free(); repeat ($urandom_range(0, 3)) @(negedge Clk); end
        2: begin
          if (cyc + 1 < fe) begin
            wait_until_edge(cyc + 1 + int'($urandom_range(0, fe - cyc - 2)));
            issue(3'($urandom_range(0, 7)), $urandom, $urandom);
          end
        end
        default: wait_free();
      endcase
      issue(rop, pick_a(), pick_b());
    end

    for (int t = 0; t < 200 && sb.size() > 0; t++) @(negedge Clk);
    if (sb.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d results still outstanding", sb.size());
    end
    wait_free(); @(negedge Clk);
    chk("final_hi", {32'd0, Hi}, {32'd0, m_hi});
    chk("final_lo", {32'd0, Lo}, {32'd0, m_lo});
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
